// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with an enable prescaler,
// selectable wrap or saturate behaviour at the boundaries, a registered
// terminal-count pulse and a sticky overflow flag.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous, active-high; clears count, prescaler and flags
//   en         - count enable, feeds the prescaler
//   up         - direction of each step (1 = increment, 0 = decrement)
//   clear      - synchronous clear of count and prescaler (highest priority)
//   load       - synchronous load of load_value, clamped to MAX_VAL
//   load_value - value applied on load
//   ovf_clr    - clears the sticky ovf flag (a same-edge boundary step wins)
//   value      - registered count, always within 0..MAX_VAL
//   tc         - one-cycle pulse following every boundary step
//   ovf        - sticky flag, set by any boundary step
module updown_mod_counter #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int               PRESCALE = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] value,
  output logic             tc,
  output logic             ovf
);

  // A one-bit prescaler is kept for PRESCALE=1; it then stays at 0 forever
  // and every enabled cycle is a step.
  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_cnt;
  logic          step;
  logic          at_bound;
  logic          bound_step;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  // Next count for one step: wrap or hold at the boundaries.
  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v,
                                                input logic             dir);
    logic [WIDTH-1:0] r;
    if (dir) begin
      if (v == MAX_VAL) r = SATURATE ? v : '0;
      else              r = v + WIDTH'(1);
    end else begin
      if (v == '0)      r = SATURATE ? v : MAX_VAL;
      else              r = v - WIDTH'(1);
    end
    return r;
  endfunction

  // A step is suppressed by clear or load, so tc and ovf only react to
  // steps that really happen.
  always_comb begin
    step       = en && (ps_cnt == PS_LAST) && !clear && !load;
    at_bound   = up ? (value == MAX_VAL) : (value == '0);
    bound_step = step && at_bound;
  end

  // Registered state: count, prescaler, tc pulse and sticky ovf
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value  <= '0;
      ps_cnt <= '0;
      tc     <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      tc <= bound_step;
      if (bound_step)   ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (clear) begin
        value  <= '0;
        ps_cnt <= '0;
      end else if (load) begin
        value  <= clamp_load(load_value);
        ps_cnt <= '0;
      end else if (en) begin
        if (ps_cnt == PS_LAST) begin
          ps_cnt <= '0;
          value  <= step_val(value, up);
        end else begin
          ps_cnt <= ps_cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Testbench for updown_mod_counter. Four instances with different
// parameter sets share clk and reset; each has its own input/output set.
//   u0: defaults (8 bit, MAX 255, PRESCALE 1, wrap)
//   u1: MAX_VAL 9, PRESCALE 3, wrap
//   u2: MAX_VAL 9, PRESCALE 1, saturate
//   u3: MAX_VAL 200, PRESCALE 1, wrap
module tb_updown_mod_counter;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en_s  [ND];
  logic       up_s  [ND];
  logic       clr_s [ND];
  logic       ld_s  [ND];
  logic       oc_s  [ND];
  logic [7:0] lv_s  [ND];
  logic [7:0] val_s [ND];
  logic       tc_s  [ND];
  logic       ovf_s [ND];

  updown_mod_counter u0 (
    .clk(clk), .reset(reset), .en(en_s[0]), .up(up_s[0]), .clear(clr_s[0]),
    .load(ld_s[0]), .load_value(lv_s[0]), .ovf_clr(oc_s[0]),
    .value(val_s[0]), .tc(tc_s[0]), .ovf(ovf_s[0]));

  updown_mod_counter #(.WIDTH(8), .MAX_VAL(8'd9), .PRESCALE(3), .SATURATE(1'b0)) u1 (
    .clk(clk), .reset(reset), .en(en_s[1]), .up(up_s[1]), .clear(clr_s[1]),
    .load(ld_s[1]), .load_value(lv_s[1]), .ovf_clr(oc_s[1]),
    .value(val_s[1]), .tc(tc_s[1]), .ovf(ovf_s[1]));

  updown_mod_counter #(.WIDTH(8), .MAX_VAL(8'd9), .PRESCALE(1), .SATURATE(1'b1)) u2 (
    .clk(clk), .reset(reset), .en(en_s[2]), .up(up_s[2]), .clear(clr_s[2]),
    .load(ld_s[2]), .load_value(lv_s[2]), .ovf_clr(oc_s[2]),
    .value(val_s[2]), .tc(tc_s[2]), .ovf(ovf_s[2]));

  updown_mod_counter #(.WIDTH(8), .MAX_VAL(8'd200), .PRESCALE(1), .SATURATE(1'b0)) u3 (
    .clk(clk), .reset(reset), .en(en_s[3]), .up(up_s[3]), .clear(clr_s[3]),
    .load(ld_s[3]), .load_value(lv_s[3]), .ovf_clr(oc_s[3]),
    .value(val_s[3]), .tc(tc_s[3]), .ovf(ovf_s[3]));

  typedef struct {
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic       up;
    logic       oc;
    logic [7:0] ev;
    logic       etc;
    logic       eov;
  } vec_t;

  typedef struct {
    int         d;
    logic [7:0] v;
    logic       tc;
    logic       ovf;
    string      tag;
  } exp_t;

  exp_t sb [$];
  vec_t tbl[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic clr, input logic ld, input logic [7:0] lv,
                              input logic en, input logic up, input logic oc,
                              input logic [7:0] ev, input logic etc, input logic eov);
    vec_t x;
    x.clr = clr; x.ld = ld; x.lv = lv; x.en = en; x.up = up; x.oc = oc;
    x.ev = ev; x.etc = etc; x.eov = eov;
    return x;
  endfunction

  task automatic expect_out(input int d, input logic [7:0] v, input logic t,
                            input logic o, input string tag);
    exp_t e;
    e.d = d; e.v = v; e.tc = t; e.ovf = o; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input int d);
    en_s[d] = 1'b0; up_s[d] = 1'b0; clr_s[d] = 1'b0;
    ld_s[d] = 1'b0; oc_s[d] = 1'b0; lv_s[d] = 8'd0;
  endtask

  task automatic drive(input int d, input vec_t x, input string tag);
    clr_s[d] = x.clr; ld_s[d] = x.ld; lv_s[d] = x.lv;
    en_s[d]  = x.en;  up_s[d] = x.up; oc_s[d] = x.oc;
    expect_out(d, x.ev, x.etc, x.eov, tag);
  endtask

  task automatic check_pending();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (val_s[e.d] !== e.v || tc_s[e.d] !== e.tc || ovf_s[e.d] !== e.ovf) begin
        n_fail++;
        $display("FAIL %s u%0d: got value=%0d tc=%b ovf=%b, want value=%0d tc=%b ovf=%b",
                 e.tag, e.d, val_s[e.d], tc_s[e.d], ovf_s[e.d], e.v, e.tc, e.ovf);
      end
    end
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #1;
    check_pending();
  endtask

  task automatic run_table(input int d, input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      drive(d, tbl[i], $sformatf("%s[%0d]", tag, i));
      edge_chk();
    end
    idle(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) idle(d);
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) expect_out(d, 8'd0, 1'b0, 1'b0, "reset_state");
    check_pending();
    #10 reset = 1'b0;   // released at t=12, between edges

    // u0: free count up through 255 and wrap
    tbl.delete();
    for (int k = 1; k <= 260; k++)
      tbl.push_back(mk(0, 0, 8'd0, 1, 1, 0, 8'(k % 256), k == 256, k >= 256));
    run_table(0, "count_wrap");

    // u0: priorities, ovf_clr vs boundary step, ovf untouched by clear/load
    tbl.delete();
    tbl.push_back(mk(1, 1, 8'd5,    1, 1, 0, 8'd0,    0, 1));
    tbl.push_back(mk(0, 1, 8'h37,   1, 1, 0, 8'h37,   0, 1));
    tbl.push_back(mk(1, 0, 8'd0,    1, 1, 0, 8'd0,    0, 1));
    tbl.push_back(mk(0, 0, 8'd0,    0, 0, 1, 8'd0,    0, 0));
    tbl.push_back(mk(0, 0, 8'd0,    1, 0, 1, 8'd255,  1, 1));
    tbl.push_back(mk(0, 0, 8'd0,    0, 0, 1, 8'd255,  0, 0));
    tbl.push_back(mk(0, 0, 8'd0,    1, 1, 0, 8'd0,    1, 1));
    tbl.push_back(mk(0, 0, 8'd0,    0, 0, 0, 8'd0,    0, 1));
    run_table(0, "prio");

    // u1: prescaled count 0..9 and wrap, hold on en=0, load resets prescaler
    tbl.delete();
    for (int k = 1; k <= 33; k++)
      tbl.push_back(mk(0, 0, 8'd0, 1, 1, 0, 8'((k / 3) % 10), k == 30, k >= 30));
    tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 8'd1, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 8'd1, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  0, 1, 0, 8'd1, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 8'd1, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 8'd2, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 8'd2, 0, 1));
    tbl.push_back(mk(0, 1, 8'd12, 1, 1, 0, 8'd9, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 8'd9, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 8'd9, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,  1, 1, 0, 8'd0, 1, 1));
    run_table(1, "prescale");

    // u2: saturating at both ends, clamped load
    tbl.delete();
    tbl.push_back(mk(0, 1, 8'd12, 0, 1, 0, 8'd9, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 8'd0, 1, 1, 0, 8'd9, 1, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 8'd0, 1, 0, 0, 8'(8 - k), 0, 1));
    tbl.push_back(mk(0, 1, 8'd1, 0, 0, 0, 8'd1, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0, 0, 8'd0, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0, 0, 8'd0, 1, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 0, 0, 8'd0, 1, 1));
    tbl.push_back(mk(0, 0, 8'd0, 1, 1, 0, 8'd1, 0, 1));
    run_table(2, "saturate");

    // u3: down-wrap to 200, direction toggling, up-wrap, clamped load
    tbl.delete();
    tbl.push_back(mk(0, 0, 8'd0,   1, 0, 0, 8'd200, 1, 1));
    tbl.push_back(mk(0, 0, 8'd0,   1, 0, 0, 8'd199, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,   1, 1, 0, 8'd200, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,   1, 0, 0, 8'd199, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,   1, 1, 0, 8'd200, 0, 1));
    tbl.push_back(mk(0, 0, 8'd0,   1, 1, 0, 8'd0,   1, 1));
    tbl.push_back(mk(0, 1, 8'd255, 1, 1, 0, 8'd200, 0, 1));
    run_table(3, "mod200");

    // Asynchronous reset mid-count (u0 at 0x37) and mid-prescale (u1)
    drive(0, mk(0, 1, 8'h37, 0, 1, 0, 8'h37, 0, 1), "pre_reset");
    drive(1, mk(0, 0, 8'd0,  1, 1, 0, 8'd0,  0, 1), "pre_reset");
    edge_chk();
    idle(0);
    idle(1);
    #3 reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) expect_out(d, 8'd0, 1'b0, 1'b0, "async_reset");
    check_pending();
    edge_chk();
    #2 reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      drive(0, mk(0, 0, 8'd0, 1, 1, 0, 8'(k),      0, 0), $sformatf("post_reset[%0d]", k));
      drive(1, mk(0, 0, 8'd0, 1, 1, 0, 8'(k / 3),  0, 0), $sformatf("post_reset[%0d]", k));
      edge_chk();
    end
    idle(0);
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the counter width in bits (2..32).
REQ-002 The block SHALL have parameter MAX_VAL, default 2**WIDTH-1, the terminal value; legal range 1..2**WIDTH-1.
REQ-003 The block SHALL have parameter PRESCALE, default 1, the number of enabled cycles per count step (1..256).
REQ-004 The block SHALL have parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port en, input, 1 bit: count enable, feeding the prescaler.
REQ-008 The block SHALL have port up, input, 1 bit: direction (1 = increment, 0 = decrement), sampled on each step.
REQ-009 The block SHALL have port clear, input, 1 bit: synchronous clear to 0.
REQ-010 The block SHALL have port load, input, 1 bit: synchronous load of load_value.
REQ-011 The block SHALL have port load_value, input, WIDTH bits: value applied on load.
REQ-012 The block SHALL have port ovf_clr, input, 1 bit: clears the sticky ovf flag.
REQ-013 The block SHALL have port value, output, WIDTH bits: the registered count.
REQ-014 The block SHALL have port tc, output, 1 bit: registered one-cycle pulse on a boundary step.
REQ-015 The block SHALL have port ovf, output, 1 bit: sticky flag, set on any boundary step.

Function
REQ-016 Per-edge priority SHALL be clear > load > step; a lower-priority action is ignored when a higher one is active.
REQ-017 clear SHALL set value to 0, reset the prescaler to 0, and force tc to 0 on that edge.
REQ-018 load SHALL set value to min(load_value, MAX_VAL), reset the prescaler to 0, and force tc to 0.
REQ-019 The prescaler SHALL count enabled cycles 0..PRESCALE-1; a step SHALL occur on the edge where en=1 and the prescaler equals PRESCALE-1, after which the prescaler returns to 0.
REQ-020 When en=0, the prescaler and value SHALL hold.
REQ-021 With PRESCALE=1, every enabled cycle SHALL be a step.
REQ-022 A non-boundary step SHALL update value to value+1 (up=1) or value-1 (up=0) on the stepping edge, with no extra latency.
REQ-023 A boundary step is defined as up=1 with value==MAX_VAL, or up=0 with value==0.
REQ-024 On a boundary step with SATURATE=0, value SHALL wrap: up=1 goes to 0; up=0 goes to MAX_VAL.
REQ-025 On a boundary step with SATURATE=1, value SHALL hold its current value.
REQ-026 tc SHALL be 1 for exactly the cycle following each boundary step edge, and 0 otherwise; consecutive boundary steps SHALL produce consecutive tc pulses.
REQ-027 ovf SHALL be set on the edge of any boundary step.
REQ-028 ovf SHALL be cleared by ovf_clr; when set and clear occur on the same edge, set SHALL win.
REQ-029 ovf SHALL NOT be affected by clear or load.
REQ-030 A direction change SHALL take effect on the next step without a glitch or skipped count.
REQ-031 value SHALL never exceed MAX_VAL under any input sequence.

Reset
REQ-032 While reset=1, value, tc, ovf and the prescaler SHALL be 0 immediately, without waiting for a clk edge.
REQ-033 Reset deassertion SHALL NOT itself cause a step; counting resumes on the first enabled edge after release.
REQ-034 Reset asserted mid-count or mid-prescale SHALL discard all partial state.

Verification
REQ-035 Defaults, en=1, up=1 held for 260 cycles -> value goes 0..255, then wraps to 0 with a tc pulse and ovf=1.
REQ-036 MAX_VAL=9, PRESCALE=3, en=1, up=1 -> value advances every 3 cycles 0..9; the step after 9 gives value=0 with tc=1 for one cycle.
REQ-037 SATURATE=1, MAX_VAL=9, load_value=12 with load=1 -> value=9; then up=1 steps -> value holds 9, tc pulses on each step, ovf=1; then up=0 -> value goes 8, 7, ...
REQ-038 load and clear asserted together with load_value=5 -> value=0; ovf_clr and a boundary step on the same edge -> ovf stays 1.
REQ-039 Reset asserted asynchronously between edges while value=0x37 and the prescaler is mid-count -> value=0, tc=0, ovf=0 immediately; the first enabled edge after release with PRESCALE=1 gives value=1.
REQ-040 up=0 from value=0, SATURATE=0, MAX_VAL=200 -> value=200, tc=1; then toggling up every step -> value alternates 199/200 with no tc.
